// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver and its helpers.
// Holds the receive FSM encoding and the oversampling constants.
package uart_defs;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } RxState_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every max(divider_i,1) clks.
// Holding clear_i keeps the phase at zero so a frame always starts aligned.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] divider_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;

  always_comb begin
    div_eff = (divider_i == '0) ? DIV_W'(1) : divider_i;
    tick_o  = !clear_i && (cnt == div_eff - DIV_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt <= '0;
    end else if (tick_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, optional parity,
// single-entry output holding register with overrun detection.
module uart_rx
  import uart_defs::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [DIV_W-1:0]     divider_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 flush_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_error_o,
  output logic                 framing_error_o,
  output logic                 overrun_error_o,
  output logic                 busy_o
);

  localparam int unsigned   SC_W     = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] MID    = SC_W'(MID_SAMPLE);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  RxState_t             state, next_state;
  logic                 rx_meta, rx_s, rx_prev;
  logic                 tick, tick_clear, mid;
  logic [SC_W-1:0]      sample_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err_q;
  logic                 stop_sample;

  assign tick_clear  = (state == IDLE);
  assign mid         = tick && (sample_cnt == MID);
  assign stop_sample = (state == STOP) && mid;
  assign busy_o      = (state != IDLE);

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tick_clear),
    .divider_i (divider_i),
    .tick_o    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (enable_i && rx_prev && !rx_s) next_state = START;
      START:  if (mid) next_state = rx_s ? IDLE : DATA;
      DATA:   if (mid && bit_cnt == LAST_BIT) next_state = parity_en_i ? PARITY : STOP;
      PARITY: if (mid) next_state = STOP;
      STOP:   if (mid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush_i || !enable_i) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta         <= 1'b1;
      rx_s            <= 1'b1;
      rx_prev         <= 1'b1;
      sample_cnt      <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      par_err_q       <= 1'b0;
      data_o          <= '0;
      valid_o         <= 1'b0;
      parity_error_o  <= 1'b0;
      framing_error_o <= 1'b0;
      overrun_error_o <= 1'b0;
    end else begin
      rx_meta         <= rx_i;
      rx_s            <= rx_meta;
      rx_prev         <= rx_s;
      parity_error_o  <= 1'b0;
      framing_error_o <= 1'b0;
      overrun_error_o <= 1'b0;

      if (state == IDLE)  sample_cnt <= '0;
      else if (tick)      sample_cnt <= sample_cnt + SC_W'(1);

      if (mid && state == START) begin
        bit_cnt   <= '0;
        par_err_q <= 1'b0;
      end
      if (mid && state == DATA) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (mid && state == PARITY) par_err_q <= ((^shift) ^ rx_s) != parity_odd_i;

      // Flush wins over a load; a disabled receiver delivers nothing but keeps the held byte.
      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (stop_sample && enable_i && (!valid_o || ready_i)) begin
        data_o          <= shift;
        valid_o         <= 1'b1;
        parity_error_o  <= par_err_q;
        framing_error_o <= !rx_s;
      end else begin
        if (stop_sample && enable_i) overrun_error_o <= 1'b1;
        if (valid_o && ready_i)      valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: one task per scenario,
// a negedge monitor counts pulses and valid_o rising edges.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b1;
  logic [15:0] divider_i = 16'd1;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        rx_i = 1'b1;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        parity_error_o, framing_error_o, overrun_error_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0, pe_cnt = 0, fe_cnt = 0, ov_cnt = 0, rise_cnt = 0, rise_cyc = 0, busy_cnt = 0;
  logic valid_q = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (enable_i),
    .divider_i       (divider_i),
    .parity_en_i     (parity_en_i),
    .parity_odd_i    (parity_odd_i),
    .flush_i         (flush_i),
    .rx_i            (rx_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .parity_error_o  (parity_error_o),
    .framing_error_o (framing_error_o),
    .overrun_error_o (overrun_error_o),
    .busy_o          (busy_o)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (parity_error_o)  pe_cnt <= pe_cnt + 1;
    if (framing_error_o) fe_cnt <= fe_cnt + 1;
    if (overrun_error_o) ov_cnt <= ov_cnt + 1;
    if (busy_o)          busy_cnt <= busy_cnt + 1;
    if (valid_o && !valid_q) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    valid_q <= valid_o;
  end

  // Serialises one frame LSB first, bit period 16*div clks, then one idle bit.
  task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit,
                            input bit stop_bit, input int div, output int fall_cyc);
    int bp;
    bp = 16 * div;
    @(negedge clk);
    rx_i = 1'b0;
    fall_cyc = cyc;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (bp) @(negedge clk);
    end
    if (par_en) begin
      rx_i = par_bit;
      repeat (bp) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (bp) @(negedge clk);
    rx_i = 1'b1;
    repeat (bp) @(negedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if ({parity_error_o, framing_error_o, overrun_error_o} !== 3'b000) begin
      errors++; $display("FAIL reset_err got %b exp 000", {parity_error_o, framing_error_o, overrun_error_o});
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int f, pe0, fe0, ov0, r0, lat;
    pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt;
    divider_i = 16'd1; parity_en_i = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1, f);
    lat = rise_cyc - f;
    checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", data_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", valid_o); end
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL basic_rises got %0d exp 1", rise_cnt - r0); end
    checks++; if (lat < 148 || lat > 162) begin errors++; $display("FAIL basic_latency got %0d exp 148..162", lat); end
    checks++; if (pe_cnt - pe0 + fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin
      errors++; $display("FAIL basic_errs got %0d exp 0", pe_cnt - pe0 + fe_cnt - fe0 + ov_cnt - ov0);
    end
    consume();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_consume got %b exp 0", valid_o); end
  endtask

  task automatic test_divider();
    int f;
    divider_i = 16'd0;
    send_frame(8'h3B, 1'b0, 1'b0, 1'b1, 1, f);
    checks++; if (data_o !== 8'h3B || valid_o !== 1'b1) begin
      errors++; $display("FAIL div0_data got %h/%b exp 3b/1", data_o, valid_o);
    end
    consume();
    divider_i = 16'd3;
    send_frame(8'hC6, 1'b0, 1'b0, 1'b1, 3, f);
    checks++; if (data_o !== 8'hC6 || valid_o !== 1'b1) begin
      errors++; $display("FAIL div3_data got %h/%b exp c6/1", data_o, valid_o);
    end
    consume();
    divider_i = 16'd1;
  endtask

  task automatic test_parity();
    int f, pe0;
    parity_en_i = 1'b1; parity_odd_i = 1'b0;
    pe0 = pe_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1, f);
    checks++; if (data_o !== 8'h3C) begin errors++; $display("FAIL par_good_data got %h exp 3c", data_o); end
    checks++; if (pe_cnt - pe0 !== 0) begin errors++; $display("FAIL par_good_err got %0d exp 0", pe_cnt - pe0); end
    consume();
    pe0 = pe_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1, f);
    checks++; if (data_o !== 8'h3C || valid_o !== 1'b1) begin
      errors++; $display("FAIL par_bad_data got %h/%b exp 3c/1", data_o, valid_o);
    end
    checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL par_bad_pulse got %0d exp 1", pe_cnt - pe0); end
    parity_en_i = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", valid_o); end
  endtask

  task automatic test_framing();
    int f, fe0, r0;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1, f);
    checks++; if (data_o !== 8'h55 || valid_o !== 1'b1) begin
      errors++; $display("FAIL frm_data got %h/%b exp 55/1", data_o, valid_o);
    end
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL frm_pulse got %0d exp 1", fe_cnt - fe0); end
    consume();
    fe0 = fe_cnt; r0 = rise_cnt;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1, f);
    checks++; if (data_o !== 8'h12 || rise_cnt - r0 !== 1) begin
      errors++; $display("FAIL frm_next got %h/%0d exp 12/1", data_o, rise_cnt - r0);
    end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL frm_next_err got %0d exp 0", fe_cnt - fe0); end
    consume();
  endtask

  task automatic test_overrun();
    int f, ov0, r0;
    ov0 = ov_cnt; r0 = rise_cnt;
    ready_i = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1, f);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1, f);
    checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulse got %0d exp 1", ov_cnt - ov0); end
    checks++; if (data_o !== 8'h11 || valid_o !== 1'b1) begin
      errors++; $display("FAIL ovr_data got %h/%b exp 11/1", data_o, valid_o);
    end
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL ovr_rises got %0d exp 1", rise_cnt - r0); end
    consume();
  endtask

  task automatic test_false_start();
    int b0, r0, e0;
    b0 = busy_cnt; r0 = rise_cnt; e0 = pe_cnt + fe_cnt + ov_cnt;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (busy_cnt - b0 <= 0) begin errors++; $display("FAIL fs_started got %0d exp >0", busy_cnt - b0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fs_busy got %b exp 0", busy_o); end
    checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL fs_valid got %0d exp 0", rise_cnt - r0); end
    checks++; if (pe_cnt + fe_cnt + ov_cnt - e0 !== 0) begin
      errors++; $display("FAIL fs_err got %0d exp 0", pe_cnt + fe_cnt + ov_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    int f, r0;
    logic [7:0] d;
    d = 8'hF0;
    r0 = rise_cnt;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      if (i == 3) begin
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
      end else if (i == 4) begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy_o); end
        repeat (12) @(negedge clk);
      end else begin
        repeat (16) @(negedge clk);
      end
    end
    rx_i = 1'b1;
    repeat (32) @(negedge clk);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1, f);
    checks++; if (data_o !== 8'h0F || rise_cnt - r0 !== 1) begin
      errors++; $display("FAIL rstmid_data got %h/%0d exp 0f/1", data_o, rise_cnt - r0);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_parity();
    test_flush();
    test_framing();
    test_overrun();
    test_false_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
